fdivsqrt_intpostproc: RTL and testbench

Integer result postprocessor for the shared divide/square-root unit. It takes the raw quotient and residual that the digit-recurrence iterator produces for integer DIV/DIVU/REM/REMU (and W variants), together with the operand metadata captured at start. It then performs residual correction, the normalization right shift, sign restoration, special-case override and W64 sign extension. It sits between the iterator and the writeback result mux as a two-stage valid/ready pipeline.

---
 rtl/fdivsqrt_intpostproc.sv | 124 ++++++++++++
 tb/tb_fdivsqrt_intpostproc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_intpostproc.sv
// rtl/fdivsqrt_intpostproc.sv - integer DIV/REM postprocessor, two-stage valid/ready pipeline
// Optional W64 sign extension enabled by defining FDIVSQRT_INTPOST_W64_EN (XLEN=64 only).
module fdivsqrt_intpostproc #(
    parameter int XLEN    = 64,
    parameter int DIVb    = 66,
    parameter int DIVBLEN = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIVb:0]      QM,
    input  logic [DIVb+3:0]    WM,
    input  logic [DIVb+3:0]    DM,
    input  logic [DIVBLEN-1:0] IntNormShiftM,
    input  logic               RemOpM,
    input  logic               ALTBM,
    input  logic               BZeroM,
    input  logic               AsM,
    input  logic               BsM,
    input  logic               W64M,
    input  logic [XLEN-1:0]    AM,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    IntDivResultM
);
    localparam int WW = DIVb + 4;

    logic              s1_valid;
    logic              s2_adv;
    logic [XLEN-1:0]   s1_sh;
    logic [XLEN-1:0]   s1_a;
    logic              s1_remop, s1_altb, s1_bzero, s1_as, s1_bs;

    logic              negres;
    logic [DIVb:0]     qc;
    logic [WW-1:0]     rc;
    logic [WW-1:0]     pre;
    logic [XLEN-1:0]   sh_next;
    logic [WW-XLEN-1:0] sh_unused;

    logic              neg;
    logic [XLEN-1:0]   mag;
    logic [XLEN-1:0]   res_next;

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;

    // A negative final residual means the iterator overshot by one quotient step.
    assign negres = WM[WW-1];
    assign qc     = QM - {{DIVb{1'b0}}, negres};
    assign rc     = WM + (negres ? DM : '0);
    assign pre    = RemOpM ? rc : {3'b000, qc};
    assign {sh_unused, sh_next} = pre >> IntNormShiftM;

`ifdef FDIVSQRT_INTPOST_W64_EN
    logic s1_w64;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_w64 <= 1'b0;
        end else if (in_ready && in_valid) begin
            s1_w64 <= W64M;
        end
    end
`else
    logic w64_unused;
    assign w64_unused = W64M;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sh    <= '0;
            s1_a     <= '0;
            s1_remop <= 1'b0;
            s1_altb  <= 1'b0;
            s1_bzero <= 1'b0;
            s1_as    <= 1'b0;
            s1_bs    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sh    <= sh_next;
                s1_a     <= AM;
                s1_remop <= RemOpM;
                s1_altb  <= ALTBM;
                s1_bzero <= BZeroM;
                s1_as    <= AsM;
                s1_bs    <= BsM;
            end
        end
    end

    // Modulo negation also covers -2^(XLEN-1) / -1 without a special case.
    assign neg = s1_remop ? s1_as : (s1_as ^ s1_bs);
    assign mag = neg ? ('0 - s1_sh) : s1_sh;

    always_comb begin
        res_next = mag;
        if (s1_bzero) begin
            res_next = s1_remop ? s1_a : '1;
        end else if (s1_altb) begin
            res_next = s1_remop ? s1_a : '0;
        end
`ifdef FDIVSQRT_INTPOST_W64_EN
        if (s1_w64) begin
            res_next = {{32{res_next[31]}}, res_next[31:0]};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            IntDivResultM <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                IntDivResultM <= res_next;
            end
        end
    end
endmodule

// File: tb/tb_fdivsqrt_intpostproc.sv
// tb/tb_fdivsqrt_intpostproc.sv - directed self-checking bench for fdivsqrt_intpostproc
module tb_fdivsqrt_intpostproc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [66:0] QM = '0;
    logic [69:0] WM = '0;
    logic [69:0] DM = '0;
    logic [6:0]  IntNormShiftM = '0;
    logic        RemOpM = 1'b0, ALTBM = 1'b0, BZeroM = 1'b0, AsM = 1'b0, BsM = 1'b0, W64M = 1'b0;
    logic [63:0] AM = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] IntDivResultM;

    int checks = 0;
    int errors = 0;

    fdivsqrt_intpostproc #(.XLEN(64), .DIVb(66), .DIVBLEN(7)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .QM(QM), .WM(WM), .DM(DM), .IntNormShiftM(IntNormShiftM), .RemOpM(RemOpM),
        .ALTBM(ALTBM), .BZeroM(BZeroM), .AsM(AsM), .BsM(BsM), .W64M(W64M), .AM(AM),
        .out_valid(out_valid), .out_ready(out_ready), .IntDivResultM(IntDivResultM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_in(input logic [66:0] qm, input logic [69:0] wm, input logic [69:0] dm,
                          input logic [6:0] sh, input logic rem, input logic altb, input logic bz,
                          input logic sa, input logic sb, input logic w64, input logic [63:0] am);
        QM = qm; WM = wm; DM = dm; IntNormShiftM = sh; RemOpM = rem; ALTBM = altb;
        BZeroM = bz; AsM = sa; BsM = sb; W64M = w64; AM = am;
    endtask

    // Sends one op with out_ready high; returns result and cycles until out_valid (-1 on timeout).
    task automatic do_op(input logic [66:0] qm, input logic [69:0] wm, input logic [69:0] dm,
                         input logic [6:0] sh, input logic rem, input logic altb, input logic bz,
                         input logic sa, input logic sb, input logic w64, input logic [63:0] am,
                         output logic [63:0] res, output int lat);
        int w;
        @(negedge clk);
        set_in(qm, wm, dm, sh, rem, altb, bz, sa, sb, w64, am);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = IntDivResultM;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (IntDivResultM !== 64'd0) begin
            errors++; $display("FAIL reset_result got %h want 0", IntDivResultM);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_div_rem;
        logic [63:0] r;
        int lat;
        // 100/7: quotient 14 and residual 2, both pre-shifted left by 3
        do_op(67'd112, 70'd16, 70'd56, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, r, lat);
        checks++;
        if (r !== 64'd14 || lat < 0) begin
            errors++; $display("FAIL div_100_7 got %h want %h", r, 64'd14);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL latency got %0d want 2", lat);
        end
        do_op(67'd112, 70'd16, 70'd56, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, r, lat);
        checks++;
        if (r !== 64'd2 || lat < 0) begin
            errors++; $display("FAIL rem_100_7 got %h want %h", r, 64'd2);
        end
    endtask

    task automatic test_negative_correction;
        logic [63:0] r;
        logic [69:0] wneg;
        int lat;
        wneg = 70'd0 - 70'd5;
        // -100/7: iterator overshoots to q=15, residual -5
        do_op(67'd15, wneg, 70'd7, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, r, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF2 || lat < 0) begin
            errors++; $display("FAIL div_neg100_7 got %h want %h", r, 64'hFFFF_FFFF_FFFF_FFF2);
        end
        do_op(67'd15, wneg, 70'd7, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, r, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat < 0) begin
            errors++; $display("FAIL rem_neg100_7 got %h want %h", r, 64'hFFFF_FFFF_FFFF_FFFE);
        end
    endtask

    task automatic test_special;
        logic [63:0] r;
        int lat;
        do_op(67'd9, 70'd3, 70'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1234, r, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat < 0) begin
            errors++; $display("FAIL divu_by_zero got %h want all ones", r);
        end
        do_op(67'd9, 70'd3, 70'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1234, r, lat);
        checks++;
        if (r !== 64'h1234 || lat < 0) begin
            errors++; $display("FAIL remu_by_zero got %h want %h", r, 64'h1234);
        end
        do_op(67'd9, 70'd3, 70'd8, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, r, lat);
        checks++;
        if (r !== 64'd0 || lat < 0) begin
            errors++; $display("FAIL div_altb got %h want 0", r);
        end
        do_op(67'd9, 70'd3, 70'd8, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, r, lat);
        checks++;
        if (r !== 64'd3 || lat < 0) begin
            errors++; $display("FAIL rem_altb got %h want 3", r);
        end
        // BZero wins over ALTB
        do_op(67'd9, 70'd3, 70'd0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd3, r, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat < 0) begin
            errors++; $display("FAIL bzero_priority got %h want all ones", r);
        end
    endtask

    task automatic test_overflow;
        logic [63:0] r;
        logic [66:0] q;
        int lat;
        q = 67'd1 << 63;
        do_op(q, 70'd0, 70'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, r, lat);
        checks++;
        if (r !== 64'h8000_0000_0000_0000 || lat < 0) begin
            errors++; $display("FAIL ovf_div got %h want 8000000000000000", r);
        end
        do_op(q, 70'd0, 70'd1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, r, lat);
        checks++;
        if (r !== 64'd0 || lat < 0) begin
            errors++; $display("FAIL ovf_rem got %h want 0", r);
        end
    endtask

    task automatic test_w64;
        logic [63:0] r;
        logic [63:0] exp;
        int lat;
`ifdef FDIVSQRT_INTPOST_W64_EN
        exp = 64'hFFFF_FFFF_8000_0000;
`else
        exp = 64'h0000_0000_8000_0000;
`endif
        do_op(67'h8000_0000, 70'd0, 70'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0000, r, lat);
        checks++;
        if (r !== exp || lat < 0) begin
            errors++; $display("FAIL divw_w64 got %h want %h", r, exp);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        out_ready = 1'b0;
        set_in(67'd5, 70'd0, 70'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd50);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_accept0 got %b want 1", in_ready);
        end
        @(negedge clk);
        QM = 67'd6;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_accept1 got %b want 1", in_ready);
        end
        @(negedge clk);
        QM = 67'd7;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_full_in_ready got %b want 0", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || IntDivResultM !== 64'd5) begin
                errors++; $display("FAIL b2b_stall%0d got v=%b d=%h want v=1 d=5", i, out_valid, IntDivResultM);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_stall_ready%0d got %b want 0", i, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_release_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || IntDivResultM !== 64'd6) begin
            errors++; $display("FAIL b2b_second got v=%b d=%h want v=1 d=6", out_valid, IntDivResultM);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || IntDivResultM !== 64'd7) begin
            errors++; $display("FAIL b2b_third got v=%b d=%h want v=1 d=7", out_valid, IntDivResultM);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        out_ready = 1'b0;
        set_in(67'd9, 70'd0, 70'd1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        in_valid = 1'b1;
        @(negedge clk);
        QM = 67'd10;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || IntDivResultM !== 64'd0) begin
            errors++; $display("FAIL midreset_clear got v=%b d=%h want v=0 d=0", out_valid, IntDivResultM);
        end
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_stale%0d got %b want 0", i, out_valid);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_div_rem();
        test_negative_correction();
        test_special();
        test_overflow();
        test_w64();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
